// File: rtl/h_pc.sv
// h_pc: Hack-style program counter with load/inc/hold, stall, wrap pulse and
// an optional LIFO return-address stack enabled by `define H_PC_RETURN_STACK_EN.
module h_pc #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             in,
    input  logic                         load,
    input  logic                         inc,
    input  logic                         stall,
    input  logic                         call,
    input  logic                         ret,
    output logic [WIDTH-1:0]             out,
    output logic                         wrap,
    output logic                         overflow,
    output logic                         underflow,
    output logic [$clog2(STACK_DEPTH):0] depth
);

    localparam int unsigned DW = $clog2(STACK_DEPTH) + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] pc_inc;

    assign pc_inc = pc_q + WIDTH'(1);

`ifdef H_PC_RETURN_STACK_EN
    localparam int unsigned PW = $clog2(STACK_DEPTH);

    logic [WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push;
    logic [PW-1:0]    push_idx;
    logic [PW-1:0]    top_idx;
    logic             stack_full;
    logic             stack_empty;

    // Power-of-two depth lets the low occupancy bits address the entries directly.
    assign push_idx    = depth_q[PW-1:0];
    assign top_idx     = push_idx - PW'(1);
    assign stack_full  = (depth_q == DW'(STACK_DEPTH));
    assign stack_empty = (depth_q == '0);
`endif

    always_comb begin
        pc_d   = pc_q;
        wrap_d = 1'b0;
`ifdef H_PC_RETURN_STACK_EN
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
`endif
        if (!stall) begin
            if (load) begin
                pc_d = in;
            end else if (inc) begin
                pc_d   = pc_inc;
                wrap_d = &pc_q;
            end
`ifdef H_PC_RETURN_STACK_EN
            // Later assignments override load/inc, giving call > ret > load > inc.
            if (call) begin
                pc_d   = in;
                wrap_d = 1'b0;
                if (stack_full) begin
                    ovf_d = 1'b1;
                end else begin
                    push    = 1'b1;
                    depth_d = depth_q + DW'(1);
                end
            end else if (ret) begin
                wrap_d = 1'b0;
                if (stack_empty) begin
                    pc_d  = pc_q;
                    unf_d = 1'b1;
                end else begin
                    pc_d    = stack_q[top_idx];
                    depth_d = depth_q - DW'(1);
                end
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q   <= '0;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = pc_q;
    assign wrap = wrap_q;

`ifdef H_PC_RETURN_STACK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign depth     = depth_q;
`else
    logic unused_stack_ports;

    assign unused_stack_ports = ^{call, ret};
    assign overflow           = 1'b0;
    assign underflow          = 1'b0;
    assign depth              = '0;
`endif

endmodule

// File: tb/tb_h_pc.sv
// Scoreboard bench for h_pc; expected state comes from a queue-based reference
// model and is compared one edge after each stimulus is driven.
module tb_h_pc;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load, inc, stall, call, ret;
    logic [15:0] out;
    logic        wrap, overflow, underflow;
    logic [3:0]  depth;

    h_pc #(.WIDTH(16), .STACK_DEPTH(8)) dut (
        .clock(clock), .reset(reset), .in(in), .load(load), .inc(inc),
        .stall(stall), .call(call), .ret(ret), .out(out), .wrap(wrap),
        .overflow(overflow), .underflow(underflow), .depth(depth)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] out;
        logic        wrap;
        logic        ovf;
        logic        unf;
        int          depth;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [15:0] m_out;
    logic        m_wrap, m_ovf, m_unf;
    logic [15:0] m_stack[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, st, ld, ic, cl, rt, input logic [15:0] d);
        logic [15:0] nxt;
        if (r) begin
            m_out = '0; m_wrap = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            m_stack.delete();
        end else if (st) begin
            m_wrap = 1'b0;
        end else begin
            m_wrap = 1'b0;
`ifdef H_PC_RETURN_STACK_EN
            if (cl) begin
                nxt = m_out + 16'd1;
                if (m_stack.size() < 8) m_stack.push_back(nxt);
                else m_ovf = 1'b1;
                m_out = d;
            end else if (rt) begin
                if (m_stack.size() > 0) m_out = m_stack.pop_back();
                else m_unf = 1'b1;
            end else
`endif
            if (ld) begin
                m_out = d;
            end else if (ic) begin
                m_wrap = (m_out == 16'hFFFF);
                m_out  = m_out + 16'd1;
            end
        end
    endtask

    task automatic step(input string tag, input logic r, st, ld, ic, cl, rt,
                        input logic [15:0] d);
        exp_t e;
        reset = r; stall = st; load = ld; inc = ic; call = cl; ret = rt; in = d;
        model_edge(r, st, ld, ic, cl, rt, d);
        e.out = m_out; e.wrap = m_wrap; e.ovf = m_ovf; e.unf = m_unf; e.tag = tag;
`ifdef H_PC_RETURN_STACK_EN
        e.depth = m_stack.size();
`else
        e.depth = 0;
`endif
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check({e.tag, ".out"},   {16'h0, out},        {16'h0, e.out});
        check({e.tag, ".wrap"},  {31'h0, wrap},       {31'h0, e.wrap});
        check({e.tag, ".ovf"},   {31'h0, overflow},   {31'h0, e.ovf});
        check({e.tag, ".unf"},   {31'h0, underflow},  {31'h0, e.unf});
        check({e.tag, ".depth"}, {28'h0, depth},      e.depth);
    endtask

    initial begin
        reset = 1'b0; in = '0; load = 0; inc = 0; stall = 0; call = 0; ret = 0;
        m_out = '0; m_wrap = 0; m_ovf = 0; m_unf = 0;
        @(posedge clock); #1;

        step("rst_ld", 1, 0, 1, 0, 0, 0, 16'h1234);
        check("rst_out_lit", {16'h0, out}, 32'h0);
        for (int unsigned i = 0; i < 3; i++) step("idle", 0, 0, 0, 0, 0, 0, 16'h5555);

        step("ld_fffe", 0, 0, 1, 0, 0, 0, 16'hFFFE);
        step("inc1", 0, 0, 0, 1, 0, 0, '0);
        check("inc1_lit", {16'h0, out}, 32'hFFFF);
        step("inc_wrap", 0, 0, 0, 1, 0, 0, '0);
        check("wrap_lit", {31'h0, wrap}, 32'h1);
        step("inc3", 0, 0, 0, 1, 0, 0, '0);
        check("nowrap_lit", {15'h0, out, wrap}, 32'h2);

        step("ld_inc", 0, 0, 1, 1, 0, 0, 16'h0040);
        step("stall1", 0, 1, 0, 1, 0, 0, '0);
        step("stall2", 0, 1, 1, 1, 1, 1, 16'h7777);
        check("stall_lit", {16'h0, out}, 32'h0040);
        step("unstall", 0, 0, 0, 1, 0, 0, '0);
        check("unstall_lit", {16'h0, out}, 32'h0041);
        step("rst_stall", 1, 1, 0, 0, 0, 0, '0);

        step("ld_10", 0, 0, 1, 0, 0, 0, 16'h0010);
        step("call", 0, 0, 0, 0, 1, 0, 16'h0200);
        step("inc_a", 0, 0, 0, 1, 0, 0, '0);
        step("inc_b", 0, 0, 0, 1, 0, 0, '0);
        step("ret", 0, 0, 0, 0, 0, 1, '0);
        step("ret_empty", 0, 0, 0, 0, 0, 1, '0);
        step("call_ret", 0, 0, 0, 0, 1, 1, 16'h0A00);
        step("ret_ld", 0, 0, 1, 0, 0, 1, 16'h0B00);

        step("rst2", 1, 0, 0, 0, 0, 0, '0);
        for (int unsigned i = 0; i < 8; i++) step("fill", 0, 0, 0, 0, 1, 0, 16'h1000 + 16'(i * 16));
        step("call_full", 0, 0, 0, 0, 1, 0, 16'h0300);
        for (int unsigned i = 0; i < 9; i++) step("unwind", 0, 0, 0, 0, 0, 1, '0);
        step("rst3", 1, 0, 0, 0, 0, 0, '0);

        step("ld_7", 0, 0, 1, 0, 0, 0, 16'h0007);
        step("call_inc", 0, 0, 0, 1, 1, 0, 16'h0500);
`ifndef H_PC_RETURN_STACK_EN
        check("off_lit", {16'h0, out}, 32'h0008);
`endif

        step("ld_ffff", 0, 0, 1, 0, 0, 0, 16'hFFFF);
        step("call_wrap", 0, 0, 0, 0, 1, 0, 16'h0123);
        step("ret_wrap", 0, 0, 0, 0, 0, 1, '0);

        for (int unsigned i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                 (($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/h_pc.md
Name: h_pc

Overview:
- 16-bit program counter for the Hack-style CPU.
- Built on the team's single-bit load register. It drives the instruction-memory address and consumes jump targets from the ALU/A-register path.
- Provides reset, jump-load, increment and hold, plus a stall input for wait states.
- Adds a wrap pulse and an optional hardware return-address stack.

Parameters:
- WIDTH, 16, counter/address width in bits.
- STACK_DEPTH, 8, return-stack entries. Used only when the optional feature is compiled in. Must be a power of two, at least 2.

Ports:
- clock  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high reset
- in  input  WIDTH  jump/call target address
- load  input  1  load `in` into the counter
- inc  input  1  increment the counter
- stall  input  1  freeze all state (reset excepted)
- call  input  1  push return address, jump to `in` (stack feature)
- ret  input  1  pop return address into the counter (stack feature)
- out  output  WIDTH  current counter value (registered)
- wrap  output  1  one-cycle pulse when an increment rolls over to 0
- overflow  output  1  sticky: call attempted with stack full
- underflow  output  1  sticky: ret attempted with stack empty
- depth  output  log2(STACK_DEPTH)+1  current stack occupancy

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on the rising edge of `clock`.
- Reset values:
  - out=0, wrap=0, overflow=0, underflow=0, depth=0.
  - Stack contents are don't-care.
- Priority, evaluated each edge: reset > stall > call > ret > load > inc > hold.
- stall=1: `out`, stack, depth and the sticky flags all hold. `wrap` is driven 0.
- load=1 (no higher-priority request): out <= in. Latency is 1 cycle; the new value is visible after the edge.
- inc=1 (no higher-priority request): out <= out+1, modulo 2^WIDTH.
  - If out was all-ones, out becomes 0 and wrap=1 for exactly that one cycle.
  - Otherwise wrap=0.
- wrap is 0 after every non-wrapping edge, including load, call, ret and hold.
- No request active: out holds.
- Simultaneous load and inc: load wins; no wrap pulse.
- call=1:
  - If depth < STACK_DEPTH: push out+1 (mod 2^WIDTH), depth+1, out <= in.
  - If the stack is full: no push, out <= in anyway, overflow <= 1 (sticky until reset).
- ret=1:
  - If depth > 0: out <= top entry, depth-1.
  - If empty: out holds, underflow <= 1 (sticky until reset).
- call and ret together: call wins, ret ignored, no flag set.
- Reset asserted mid-sequence, including with stall=1: everything returns to reset values on that edge. The stack is logically emptied (depth=0).
- `out` is a pure register output; no combinational path from any input to `out`.
- `wrap` is registered.
- Stack is LIFO, implemented as registers plus a pointer; no RAM inference is required.

Optional Feature:
- Macro: H_PC_RETURN_STACK_EN.
- Defined:
  - Return stack, call/ret handling, overflow, underflow and depth are all active as described above.
- Undefined:
  - The call and ret ports still exist but are ignored entirely.
  - The priority chain becomes reset > stall > load > inc > hold.
  - overflow, underflow and depth are tied to 0.
  - No stack storage is synthesized.
- Port list is identical in both builds.

Test Plan:
- Reset then hold: reset=1 for 1 cycle with in=0x1234 and load=1 -> out=0x0000, wrap=0. Next 3 idle cycles -> out stays 0x0000.
- Increment and wrap: load 0xFFFE, then inc for 3 cycles -> out 0xFFFF, 0x0000 (wrap=1 this cycle only), 0x0001 (wrap=0).
- Priority and stall:
  - load=1, inc=1, in=0x0040 -> out=0x0040.
  - Then stall=1 with inc=1 for 2 cycles -> out stays 0x0040.
  - Release stall -> 0x0041.
- Call/return (feature on):
  - At out=0x0010, call with in=0x0200 -> out=0x0200, depth=1.
  - inc twice -> 0x0202.
  - ret -> out=0x0011, depth=0.
  - ret again -> out holds 0x0011, underflow=1.
- Stack full (feature on, STACK_DEPTH=8):
  - 8 calls -> depth=8.
  - 9th call with in=0x0300 -> out=0x0300, depth=8, overflow=1.
  - 8 rets unwind in LIFO order.
  - Reset -> overflow=0, depth=0.
- Feature off: call=1, in=0x0500, at out=0x0007 -> out=0x0007 (ignored). Simultaneous inc=1 -> 0x0008. depth, overflow and underflow are constantly 0.
